// File: rtl/cmp_pkg.sv
// Shared result encoding and FSM state type for the serial magnitude comparators.
package cmp_pkg;

  localparam logic [1:0] CMP_NONE = 2'b00;
  localparam logic [1:0] CMP_GT   = 2'b01;
  localparam logic [1:0] CMP_LT   = 2'b10;
  localparam logic [1:0] CMP_EQ   = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/compare_slice.sv
// Combinational unsigned compare of one STEP-bit slice; eq is implied by !gt && !lt.
module compare_slice #(
  parameter int STEP = 4
) (
  input  logic [STEP-1:0] x,
  input  logic [STEP-1:0] y,
  output logic            gt,
  output logic            lt
);

  always_comb begin
    gt = (x > y);
    lt = (x < y);
  end

endmodule

// File: rtl/compare_serial_param.sv
// Multi-cycle MSB-first magnitude comparator scanning STEP bits per cycle,
// exiting at the first differing slice; signed mode uses offset-binary capture.
module compare_serial_param
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [1:0]       o
);

  localparam int NSLICE = WIDTH / STEP;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       o_q, o_d;

  logic [WIDTH-1:0] sh_a, sh_b;
  logic [31:0]      shamt;
  logic             sl_gt, sl_lt;

  // Shift the current slice up to the MSB end so a constant part-select picks it.
  always_comb begin
    shamt = 32'(idx_q) * 32'(STEP);
    sh_a  = ra_q << shamt;
    sh_b  = rb_q << shamt;
  end

  compare_slice #(.STEP(STEP)) u_slice (
    .x  (sh_a[WIDTH-1 -: STEP]),
    .y  (sh_b[WIDTH-1 -: STEP]),
    .gt (sl_gt),
    .lt (sl_lt)
  );

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    o_d     = o_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Flipping both MSBs maps two's-complement order onto unsigned order.
          ra_d    = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
          rb_d    = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
          idx_d   = '0;
          busy_d  = 1'b1;
          o_d     = CMP_NONE;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          busy_d  = 1'b0;
          o_d     = CMP_NONE;
          state_d = IDLE;
        end else if (sl_gt || sl_lt) begin
          o_d     = sl_gt ? CMP_GT : CMP_LT;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (idx_q == LAST_IDX) begin
          o_d     = CMP_EQ;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      o_q     <= CMP_NONE;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      o_q     <= o_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign o    = o_q;

endmodule

// File: tb/tb_compare_serial_param.sv
// Drives four comparator instances (STEP 1/2/4/16, WIDTH 16) in lockstep and
// checks result and latency against a plain-arithmetic reference model.
module tb_compare_serial_param;

  localparam int W = 16;
  localparam int ND = 4;
  localparam int STEPS [ND] = '{1, 2, 4, 16};
  localparam int BUDGET = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          signed_mode = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          abort = 1'b0;
  logic          busy_w [ND];
  logic          done_w [ND];
  logic [1:0]    o_w    [ND];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  compare_serial_param #(.WIDTH(W), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .abort(abort), .busy(busy_w[0]), .done(done_w[0]), .o(o_w[0]));
  compare_serial_param #(.WIDTH(W), .STEP(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .abort(abort), .busy(busy_w[1]), .done(done_w[1]), .o(o_w[1]));
  compare_serial_param #(.WIDTH(W), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .abort(abort), .busy(busy_w[2]), .done(done_w[2]), .o(o_w[2]));
  compare_serial_param #(.WIDTH(W), .STEP(16)) u_s16 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .abort(abort), .busy(busy_w[3]), .done(done_w[3]), .o(o_w[3]));

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_o(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic sm);
    int sx, sy;
    if (sm) begin
      sx = int'($signed(x));
      sy = int'($signed(y));
    end else begin
      sx = int'(x);
      sy = int'(y);
    end
    if (sx > sy) return 2'b01;
    if (sx < sy) return 2'b10;
    return 2'b11;
  endfunction

  // Edges from the start edge to done: first differing slice index + 1, or NSLICE if equal.
  function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y, input int step);
    int diff, ns, mask;
    diff = int'(x ^ y);
    ns   = W / step;
    mask = (1 << step) - 1;
    for (int i = 0; i < ns; i++)
      if (((diff >> (W - step * (i + 1))) & mask) != 0) return i + 1;
    return ns;
  endfunction

  task automatic run_cmp(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic sm,
                         input bit repulse);
    logic [1:0] exp_o;
    int         exp_lat [ND];
    bit         seen    [ND];
    exp_o = model_o(xa, xb, sm);
    for (int j = 0; j < ND; j++) begin
      exp_lat[j] = model_lat(xa, xb, STEPS[j]);
      seen[j]    = 1'b0;
    end
    @(negedge clk);
    start = 1'b1; a = xa; b = xb; signed_mode = sm;
    @(posedge clk);
    @(negedge clk);
    // Operands are don't-care after capture; a re-pulsed start must be ignored.
    start = repulse; a = 16'($urandom); b = 16'($urandom); signed_mode = ~sm;
    for (int j = 0; j < ND; j++) begin
      check_eq("busy_after_start", 32'(busy_w[j]), 1);
      check_eq("o_while_busy", 32'(o_w[j]), 0);
    end
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int j = 0; j < ND; j++) begin
        if (!seen[j]) begin
          if (done_w[j]) begin
            seen[j] = 1'b1;
            check_eq($sformatf("lat_step%0d", STEPS[j]), cyc, exp_lat[j]);
            check_eq($sformatf("o_step%0d", STEPS[j]), 32'(o_w[j]), 32'(exp_o));
            check_eq("busy_at_done", 32'(busy_w[j]), 0);
          end else begin
            check_eq("busy_during_scan", 32'(busy_w[j]), 1);
          end
        end else begin
          check_eq("done_one_cycle", 32'(done_w[j]), 0);
          check_eq("o_hold", 32'(o_w[j]), 32'(exp_o));
        end
      end
    end
    for (int j = 0; j < ND; j++)
      if (!seen[j]) check_eq($sformatf("timeout_step%0d", STEPS[j]), 0, 1);
  endtask

  task automatic abort_test();
    @(negedge clk);
    start = 1'b1; a = 16'h5A5A; b = 16'h5A5A; signed_mode = 1'b0;
    @(posedge clk);                 // edge k
    @(negedge clk); start = 1'b0;
    @(posedge clk);                 // edge k+1
    @(negedge clk);
    check_eq("abort_s16_done", 32'(done_w[3]), 1);
    for (int j = 0; j < 3; j++) check_eq("abort_pre_done", 32'(done_w[j]), 0);
    abort = 1'b1;
    @(posedge clk);                 // edge k+2
    @(negedge clk); abort = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check_eq("abort_busy", 32'(busy_w[j]), 0);
      check_eq("abort_o", 32'(o_w[j]), 0);
      check_eq("abort_done", 32'(done_w[j]), 0);
    end
    check_eq("abort_idle_ignored_o", 32'(o_w[3]), 32'(2'b11));
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) check_eq("abort_no_late_done", 32'(done_w[j]), 0);
    end
  endtask

  task automatic reset_test();
    @(negedge clk);
    start = 1'b1; a = 16'h5A5A; b = 16'h5A5A; signed_mode = 1'b0;
    @(posedge clk);                 // edge k
    @(negedge clk); start = 1'b0;
    @(posedge clk);                 // edge k+1
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int j = 0; j < ND; j++) begin
      check_eq("rst_busy", 32'(busy_w[j]), 0);
      check_eq("rst_done", 32'(done_w[j]), 0);
      check_eq("rst_o", 32'(o_w[j]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      for (int j = 0; j < ND; j++) check_eq("rst_no_done", 32'(done_w[j]), 0);
    end
  endtask

  initial begin
    logic [W-1:0] corners [5];
    logic [W-1:0] ra, rb;
    corners = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001};

    repeat (3) @(negedge clk);
    for (int j = 0; j < ND; j++) begin
      check_eq("reset_busy", 32'(busy_w[j]), 0);
      check_eq("reset_done", 32'(done_w[j]), 0);
      check_eq("reset_o", 32'(o_w[j]), 0);
    end
    rst_n = 1'b1;

    run_cmp(16'h1234, 16'h0234, 1'b0, 1'b0);
    run_cmp(16'hABCD, 16'hABCE, 1'b0, 1'b0);
    run_cmp(16'h5A5A, 16'h5A5A, 1'b0, 1'b0);
    run_cmp(16'hFFFF, 16'h0001, 1'b1, 1'b0);
    run_cmp(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_cmp(16'h8000, 16'h7FFF, 1'b1, 1'b0);
    run_cmp(16'h1234, 16'h0234, 1'b0, 1'b1);
    run_cmp(16'h5A5A, 16'h5A5A, 1'b1, 1'b1);

    abort_test();
    reset_test();
    run_cmp(16'hABCD, 16'hABCE, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 5; k++) begin
        run_cmp(corners[i], corners[k], 1'b0, 1'b0);
        run_cmp(corners[i], corners[k], 1'b1, 1'b0);
      end

    for (int n = 0; n < 2000; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(3))
        0:       rb = ra;
        1:       rb = ra ^ (16'h1 << $urandom_range(15));
        default: rb = 16'($urandom);
      endcase
      run_cmp(ra, rb, 1'($urandom), 1'($urandom_range(7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
